// File: rtl/rom2ram_loader_pkg.sv
// Shared constants for the boot-time flash-to-SRAM ROM loader.
// Latency: n/a (constants and a helper only).
// Backpressure: n/a.
package rom2ram_loader_pkg;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;
    localparam int         CMD_BITS     = 32;
    localparam int         DATA_BITS    = 8;

    // Read command word as it goes out on MOSI, MSB first.
    function automatic logic [31:0] read_cmd(input logic [23:0] addr);
        return {SPI_CMD_READ, addr};
    endfunction

endpackage

// File: rtl/rom2ram_loader_spi.sv
// SPI mode-0 shifter: clocks out nbits MSB-first, keeps the last 8 received bits.
// Latency: 2*SCK_HALF cycles per bit; done_pulse is combinational on the final falling-edge cycle.
// Backpressure: go is taken only while idle or on done_pulse; SCK parks low between transfers.
module spi_byte_shifter #(
    parameter int SCK_HALF = 2
) (
    input  logic        clk28,
    input  logic        rst,
    input  logic        go,
    input  logic [5:0]  nbits,
    input  logic [31:0] tx_dat,
    input  logic        spi_miso,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        busy,
    output logic        done_pulse,
    output logic [7:0]  rx_dat
);
    localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

    logic [HW-1:0] half_cnt;
    logic [5:0]    bit_cnt;
    logic [5:0]    nbits_q;
    logic [31:0]   tx_sh;
    logic          half_end;

    assign half_end   = (half_cnt == HW'(SCK_HALF - 1));
    assign done_pulse = busy && half_end && spi_sck && (bit_cnt == nbits_q - 6'd1);

    always_ff @(posedge clk28) begin
        if (rst) begin
            busy     <= 1'b0;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            nbits_q  <= '0;
            tx_sh    <= '0;
            rx_dat   <= '0;
        end else if (go) begin
            busy     <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= tx_dat[31];
            half_cnt <= '0;
            bit_cnt  <= '0;
            nbits_q  <= nbits;
            tx_sh    <= {tx_dat[30:0], 1'b0};
            rx_dat   <= '0;
        end else if (busy) begin
            if (half_end) begin
                half_cnt <= '0;
                spi_sck  <= ~spi_sck;
                // MISO is taken on the same edge that raises SCK; MOSI moves on the falling edge.
                if (!spi_sck) begin
                    rx_dat <= {rx_dat[6:0], spi_miso};
                end else if (done_pulse) begin
                    busy     <= 1'b0;
                    spi_mosi <= 1'b0;
                end else begin
                    spi_mosi <= tx_sh[31];
                    tx_sh    <= {tx_sh[30:0], 1'b0};
                    bit_cnt  <= bit_cnt + 6'd1;
                end
            end else begin
                half_cnt <= half_cnt + HW'(1);
            end
        end
    end

endmodule

// File: rtl/rom2ram_loader.sv
// Copies LOAD_BYTES from SPI flash at FLASH_BASE into SRAM at boot, holding the CPU off via active.
// Latency: first write strobe 80*SCK_HALF cycles after start; then 16*SCK_HALF+WR_CYCLES per byte.
// Backpressure: none; wren overrides SRAM traffic and the SPI clock simply stalls low during writes.
module rom2ram_loader
    import rom2ram_loader_pkg::*;
#(
    parameter logic [23:0] FLASH_BASE = 24'h080000,
    parameter logic [16:0] LOAD_BYTES = 17'h1C000,
    parameter int          SCK_HALF   = 2,
    parameter int          WR_CYCLES  = 3
) (
    input  logic        clk28,
    input  logic        rst,
    input  logic        start,
    input  logic        spi_miso,
    output logic        spi_sck,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    output logic [16:0] rom2ram_ram_address,
    output logic        rom2ram_ram_wren,
    output logic [7:0]  rom2ram_dataout,
    output logic        active,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, CMD, DATA, WRITE, DONE} state_t;

    localparam logic [16:0] LAST_ADDR = LOAD_BYTES - 17'd1;
    localparam int          WW        = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

    state_t        state, state_nxt;
    logic [16:0]   cnt, cnt_nxt;
    logic [WW-1:0] wr_cnt, wr_cnt_nxt;
    logic          cs_n_nxt, wren_nxt, active_nxt, done_nxt;
    logic [7:0]    dat_nxt;
    logic          go_req, go;
    logic [5:0]    nbits;
    logic [31:0]   tx_dat;
    logic          sh_busy, sh_done;
    logic [7:0]    rx_dat;

    assign rom2ram_ram_address = cnt;
    assign go = go_req && (!sh_busy || sh_done);

    spi_byte_shifter #(
        .SCK_HALF(SCK_HALF)
    ) u_spi (
        .clk28     (clk28),
        .rst       (rst),
        .go        (go),
        .nbits     (nbits),
        .tx_dat    (tx_dat),
        .spi_miso  (spi_miso),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .busy      (sh_busy),
        .done_pulse(sh_done),
        .rx_dat    (rx_dat)
    );

    always_ff @(posedge clk28) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            wr_cnt           <= '0;
            spi_cs_n         <= 1'b1;
            rom2ram_ram_wren <= 1'b0;
            rom2ram_dataout  <= '0;
            active           <= 1'b0;
            done             <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            wr_cnt           <= wr_cnt_nxt;
            spi_cs_n         <= cs_n_nxt;
            rom2ram_ram_wren <= wren_nxt;
            rom2ram_dataout  <= dat_nxt;
            active           <= active_nxt;
            done             <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        wr_cnt_nxt = wr_cnt;
        cs_n_nxt   = spi_cs_n;
        wren_nxt   = 1'b0;
        dat_nxt    = rom2ram_dataout;
        active_nxt = active;
        done_nxt   = done;
        go_req     = 1'b0;
        nbits      = 6'(DATA_BITS);
        tx_dat     = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (LOAD_BYTES != 17'd0) begin
                        state_nxt  = CMD;
                        cs_n_nxt   = 1'b0;
                        active_nxt = 1'b1;
                        go_req     = 1'b1;
                        nbits      = 6'(CMD_BITS);
                        tx_dat     = read_cmd(FLASH_BASE);
                    end else begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            CMD: begin
                if (sh_done) begin
                    state_nxt = DATA;
                    go_req    = 1'b1;
                end
            end
            DATA: begin
                if (sh_done) begin
                    state_nxt  = WRITE;
                    wren_nxt   = 1'b1;
                    dat_nxt    = rx_dat;
                    wr_cnt_nxt = '0;
                end
            end
            WRITE: begin
                wren_nxt = 1'b1;
                if (wr_cnt == WW'(WR_CYCLES - 1)) begin
                    wren_nxt = 1'b0;
                    if (cnt == LAST_ADDR) begin
                        state_nxt  = DONE;
                        cs_n_nxt   = 1'b1;
                        active_nxt = 1'b0;
                        done_nxt   = 1'b1;
                    end else begin
                        state_nxt = DATA;
                        cnt_nxt   = cnt + 17'd1;
                        go_req    = 1'b1;
                    end
                end else begin
                    wr_cnt_nxt = wr_cnt + WW'(1);
                end
            end
            DONE: begin
                // Sticky until reset; start is deliberately ignored here.
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rom2ram_loader.sv
module tb_rom2ram_loader;
    localparam logic [23:0] BASE    = 24'h080000;
    localparam int          A_BYTES = 16;
    localparam int          A_HALF  = 2;
    localparam int          A_WR    = 3;
    localparam int          C_BYTES = 300;

    logic clk28 = 1'b0;
    logic rst   = 1'b1;
    always #5 clk28 = ~clk28;

    int checks = 0;
    int errors = 0;

    // Instance A: default timing, 16 bytes.
    logic a_start = 1'b0, a_miso = 1'b0;
    logic a_sck, a_cs_n, a_mosi, a_wren, a_active, a_done;
    logic [16:0] a_addr;
    logic [7:0]  a_dout;
    rom2ram_loader #(.FLASH_BASE(BASE), .LOAD_BYTES(17'(A_BYTES)), .SCK_HALF(A_HALF), .WR_CYCLES(A_WR)) dut_a (
        .clk28(clk28), .rst(rst), .start(a_start), .spi_miso(a_miso), .spi_sck(a_sck), .spi_cs_n(a_cs_n),
        .spi_mosi(a_mosi), .rom2ram_ram_address(a_addr), .rom2ram_ram_wren(a_wren), .rom2ram_dataout(a_dout),
        .active(a_active), .done(a_done));

    // Instance B: zero-length image.
    logic b_start = 1'b0;
    logic b_sck, b_cs_n, b_mosi, b_wren, b_active, b_done;
    logic [16:0] b_addr;
    logic [7:0]  b_dout;
    rom2ram_loader #(.FLASH_BASE(BASE), .LOAD_BYTES(17'd0), .SCK_HALF(A_HALF), .WR_CYCLES(A_WR)) dut_b (
        .clk28(clk28), .rst(rst), .start(b_start), .spi_miso(1'b0), .spi_sck(b_sck), .spi_cs_n(b_cs_n),
        .spi_mosi(b_mosi), .rom2ram_ram_address(b_addr), .rom2ram_ram_wren(b_wren), .rom2ram_dataout(b_dout),
        .active(b_active), .done(b_done));

    // Instance C: fastest timing, random image contents.
    logic c_start = 1'b0, c_miso = 1'b0;
    logic c_sck, c_cs_n, c_mosi, c_wren, c_active, c_done;
    logic [16:0] c_addr;
    logic [7:0]  c_dout;
    rom2ram_loader #(.FLASH_BASE(BASE), .LOAD_BYTES(17'(C_BYTES)), .SCK_HALF(1), .WR_CYCLES(1)) dut_c (
        .clk28(clk28), .rst(rst), .start(c_start), .spi_miso(c_miso), .spi_sck(c_sck), .spi_cs_n(c_cs_n),
        .spi_mosi(c_mosi), .rom2ram_ram_address(c_addr), .rom2ram_ram_wren(c_wren), .rom2ram_dataout(c_dout),
        .active(c_active), .done(c_done));

    logic [7:0] c_mem [C_BYTES];

    // Flash models: 32-bit command captured on SCK rise, data driven on SCK fall from the commanded address.
    function automatic logic a_flash_bit(input logic [23:0] cmd_addr, input int idx);
        logic [23:0] addr;
        logic [7:0]  b;
        addr = cmd_addr + 24'(idx / 8);
        b = 8'(addr - BASE);
        return b[7 - (idx % 8)];
    endfunction

    function automatic logic c_flash_bit(input logic [23:0] cmd_addr, input int idx);
        int         off;
        logic [7:0] b;
        off = int'(cmd_addr - BASE) + idx / 8;
        b = (off >= 0 && off < C_BYTES) ? c_mem[off] : 8'h00;
        return b[7 - (idx % 8)];
    endfunction

    int a_bits = 0, c_bits = 0;
    logic [31:0] a_cmd = '0, c_cmd = '0;
    always @(negedge a_cs_n) begin a_bits = 0; a_cmd = '0; end
    always @(posedge a_sck) if (a_cs_n === 1'b0) begin
        if (a_bits < 32) a_cmd = {a_cmd[30:0], a_mosi};
        a_bits++;
    end
    always @(negedge a_sck) if (a_cs_n === 1'b0 && a_bits >= 32) a_miso = a_flash_bit(a_cmd[23:0], a_bits - 32);

    always @(negedge c_cs_n) begin c_bits = 0; c_cmd = '0; end
    always @(posedge c_sck) if (c_cs_n === 1'b0) begin
        if (c_bits < 32) c_cmd = {c_cmd[30:0], c_mosi};
        c_bits++;
    end
    always @(negedge c_sck) if (c_cs_n === 1'b0 && c_bits >= 32) c_miso = c_flash_bit(c_cmd[23:0], c_bits - 32);

    // SRAM-side monitors: one record per wren pulse.
    logic [16:0] a_wr_addr[$], c_wr_addr[$];
    logic [7:0]  a_wr_dat[$],  c_wr_dat[$];
    int          a_wr_len[$],  c_wr_len[$];
    int a_cur_len = 0, c_cur_len = 0, a_unstable = 0, a_cs_gap = 0;
    logic a_wren_q = 1'b0, c_wren_q = 1'b0;

    always @(negedge clk28) begin
        if (a_wren === 1'b1) begin
            if (!a_wren_q) begin
                a_wr_addr.push_back(a_addr); a_wr_dat.push_back(a_dout); a_cur_len = 0;
            end else if (a_addr !== a_wr_addr[$] || a_dout !== a_wr_dat[$]) a_unstable++;
            a_cur_len++;
        end else if (a_wren_q) a_wr_len.push_back(a_cur_len);
        if (a_active === 1'b1 && a_cs_n !== 1'b0) a_cs_gap++;
        a_wren_q <= (a_wren === 1'b1);
    end

    always @(negedge clk28) begin
        if (c_wren === 1'b1) begin
            if (!c_wren_q) begin
                c_wr_addr.push_back(c_addr); c_wr_dat.push_back(c_dout); c_cur_len = 0;
            end
            c_cur_len++;
        end else if (c_wren_q) c_wr_len.push_back(c_cur_len);
        c_wren_q <= (c_wren === 1'b1);
    end

    int b_sck_rises = 0, b_wren_cnt = 0;
    always @(posedge b_sck) b_sck_rises++;
    always @(negedge clk28) if (b_wren === 1'b1) b_wren_cnt++;

    // Reference: byte i of the image lands at SRAM address i with flash contents i & 0xFF.
    function automatic int a_seq_bad();
        int bad = 0;
        for (int i = 0; i < a_wr_addr.size(); i++) begin
            if (a_wr_addr[i] !== 17'(i) || a_wr_dat[i] !== 8'(i)) bad++;
            if (i < a_wr_len.size() && a_wr_len[i] != A_WR) bad++;
        end
        if (a_wr_len.size() != a_wr_addr.size()) bad++;
        return bad;
    endfunction

    function automatic int c_seq_bad();
        int bad = 0;
        for (int i = 0; i < c_wr_addr.size(); i++) begin
            if (i >= C_BYTES || c_wr_addr[i] !== 17'(i) || c_wr_dat[i] !== c_mem[i]) bad++;
            if (i < c_wr_len.size() && c_wr_len[i] != 1) bad++;
        end
        return bad;
    endfunction

    task automatic clear_a();
        a_wr_addr.delete(); a_wr_dat.delete(); a_wr_len.delete();
        a_unstable = 0; a_cs_gap = 0;
    endtask

    task automatic do_reset();
        @(negedge clk28);
        rst = 1'b1; a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        repeat (3) @(negedge clk28);
        rst = 1'b0;
    endtask

    task automatic pulse_a_start();
        a_start = 1'b1;
        @(negedge clk28);
        a_start = 1'b0;
    endtask

    task automatic wait_a_done(input string name);
        int cyc = 0;
        while (a_done !== 1'b1 && cyc < 20000) begin @(negedge clk28); cyc++; end
        checks++;
        if (a_done !== 1'b1) begin errors++; $display("FAIL %s_done_timeout: done=%b after %0d cycles, want 1", name, a_done, cyc); end
        @(negedge clk28);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (a_cs_n !== 1'b1)   begin errors++; $display("FAIL reset_cs_n: got %b want 1", a_cs_n); end
        checks++; if (a_sck !== 1'b0)    begin errors++; $display("FAIL reset_sck: got %b want 0", a_sck); end
        checks++; if (a_mosi !== 1'b0)   begin errors++; $display("FAIL reset_mosi: got %b want 0", a_mosi); end
        checks++; if (a_wren !== 1'b0)   begin errors++; $display("FAIL reset_wren: got %b want 0", a_wren); end
        checks++; if (a_addr !== 17'd0)  begin errors++; $display("FAIL reset_addr: got %h want 0", a_addr); end
        checks++; if (a_dout !== 8'd0)   begin errors++; $display("FAIL reset_dout: got %h want 0", a_dout); end
        checks++; if (a_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", a_active); end
        checks++; if (a_done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b want 0", a_done); end
    endtask

    task automatic test_copy();
        int lat;
        do_reset(); clear_a();
        repeat ($urandom_range(1, 20)) @(negedge clk28);
        pulse_a_start();
        checks++; if (a_active !== 1'b1) begin errors++; $display("FAIL copy_active_on_accept: got %b want 1", a_active); end
        checks++; if (a_cs_n !== 1'b0)   begin errors++; $display("FAIL copy_cs_fall_on_accept: got %b want 0", a_cs_n); end
        lat = 0;
        while (a_wren !== 1'b1 && lat < 1000) begin @(negedge clk28); lat++; end
        checks++;
        if (lat < 2*A_HALF*40 || lat > 2*A_HALF*40 + 2) begin
            errors++; $display("FAIL copy_first_write_latency: got %0d want %0d +/-1", lat, 2*A_HALF*40 + 1);
        end
        wait_a_done("copy");
        checks++; if (a_wr_addr.size() != A_BYTES) begin errors++; $display("FAIL copy_write_count: got %0d want %0d", a_wr_addr.size(), A_BYTES); end
        checks++; if (a_seq_bad() != 0) begin errors++; $display("FAIL copy_write_sequence: %0d bad records, want 0", a_seq_bad()); end
        checks++; if (a_cmd !== {8'h03, BASE}) begin errors++; $display("FAIL copy_mosi_cmd: got %h want %h", a_cmd, {8'h03, BASE}); end
        checks++; if (a_cs_gap != 0)   begin errors++; $display("FAIL copy_cs_low_while_active: %0d high cycles, want 0", a_cs_gap); end
        checks++; if (a_unstable != 0) begin errors++; $display("FAIL copy_write_stable: %0d changes, want 0", a_unstable); end
        checks++; if (a_active !== 1'b0) begin errors++; $display("FAIL copy_active_after_done: got %b want 0", a_active); end
        checks++; if (a_cs_n !== 1'b1)   begin errors++; $display("FAIL copy_cs_after_done: got %b want 1", a_cs_n); end
    endtask

    task automatic test_abort();
        int n = 0, cyc = 0;
        logic prev = 1'b0;
        do_reset(); clear_a();
        pulse_a_start();
        while (n < 5 && cyc < 20000) begin
            @(negedge clk28); cyc++;
            if (a_wren === 1'b1 && !prev) n++;
            prev = (a_wren === 1'b1);
        end
        checks++; if (n != 5) begin errors++; $display("FAIL abort_reach_5th_write: got %0d pulses want 5", n); end
        rst = 1'b1;
        @(negedge clk28);
        checks++; if (a_wren !== 1'b0) begin errors++; $display("FAIL abort_wren: got %b want 0", a_wren); end
        checks++; if (a_cs_n !== 1'b1) begin errors++; $display("FAIL abort_cs_n: got %b want 1", a_cs_n); end
        checks++; if (a_addr !== 17'd0) begin errors++; $display("FAIL abort_addr: got %h want 0", a_addr); end
        rst = 1'b0;
        @(negedge clk28);
        clear_a();
        pulse_a_start();
        wait_a_done("abort_restart");
        checks++; if (a_wr_addr.size() != A_BYTES) begin errors++; $display("FAIL abort_restart_count: got %0d want %0d", a_wr_addr.size(), A_BYTES); end
        checks++; if (a_seq_bad() != 0) begin errors++; $display("FAIL abort_restart_sequence: %0d bad records, want 0", a_seq_bad()); end
        checks++; if (a_cmd !== {8'h03, BASE}) begin errors++; $display("FAIL abort_restart_cmd: got %h want %h", a_cmd, {8'h03, BASE}); end
    endtask

    task automatic test_extra_start();
        int cyc = 0;
        do_reset(); clear_a();
        pulse_a_start();
        repeat ($urandom_range(10, 150)) @(negedge clk28);
        pulse_a_start();
        while (a_wr_len.size() < 3 && cyc < 20000) begin @(negedge clk28); cyc++; end
        repeat ($urandom_range(0, 4)) @(negedge clk28);
        pulse_a_start();
        repeat ($urandom_range(1, 60)) @(negedge clk28);
        pulse_a_start();
        wait_a_done("extra");
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(1, 10)) @(negedge clk28);
            pulse_a_start();
        end
        repeat (40) @(negedge clk28);
        checks++; if (a_wr_addr.size() != A_BYTES) begin errors++; $display("FAIL extra_write_count: got %0d want %0d", a_wr_addr.size(), A_BYTES); end
        checks++; if (a_seq_bad() != 0) begin errors++; $display("FAIL extra_write_sequence: %0d bad records, want 0", a_seq_bad()); end
        checks++; if (a_done !== 1'b1)   begin errors++; $display("FAIL extra_done_sticky: got %b want 1", a_done); end
        checks++; if (a_active !== 1'b0) begin errors++; $display("FAIL extra_active: got %b want 0", a_active); end
        checks++; if (a_cs_n !== 1'b1)   begin errors++; $display("FAIL extra_cs_n: got %b want 1", a_cs_n); end
    endtask

    task automatic test_zero_len();
        do_reset();
        b_sck_rises = 0; b_wren_cnt = 0;
        repeat ($urandom_range(1, 10)) @(negedge clk28);
        b_start = 1'b1;
        @(negedge clk28);
        b_start = 1'b0;
        checks++; if (b_done !== 1'b1)   begin errors++; $display("FAIL zero_done_next_cycle: got %b want 1", b_done); end
        checks++; if (b_active !== 1'b0) begin errors++; $display("FAIL zero_active: got %b want 0", b_active); end
        repeat (30) @(negedge clk28);
        checks++; if (b_sck_rises != 0) begin errors++; $display("FAIL zero_sck_edges: got %0d want 0", b_sck_rises); end
        checks++; if (b_wren_cnt != 0)  begin errors++; $display("FAIL zero_wren: got %0d want 0", b_wren_cnt); end
        checks++; if (b_cs_n !== 1'b1)  begin errors++; $display("FAIL zero_cs_n: got %b want 1", b_cs_n); end
        checks++; if (b_done !== 1'b1)  begin errors++; $display("FAIL zero_done_sticky: got %b want 1", b_done); end
    endtask

    task automatic test_fast();
        int lat = 0, cyc = 0;
        for (int i = 0; i < C_BYTES; i++) c_mem[i] = 8'($urandom);
        do_reset();
        c_wr_addr.delete(); c_wr_dat.delete(); c_wr_len.delete();
        c_start = 1'b1;
        @(negedge clk28);
        c_start = 1'b0;
        while (c_wren !== 1'b1 && lat < 1000) begin @(negedge clk28); lat++; end
        checks++; if (lat < 80 || lat > 82) begin errors++; $display("FAIL fast_first_write_latency: got %0d want 81 +/-1", lat); end
        while (c_done !== 1'b1 && cyc < 20000) begin @(negedge clk28); cyc++; end
        checks++; if (c_done !== 1'b1) begin errors++; $display("FAIL fast_done_timeout: done=%b, want 1", c_done); end
        @(negedge clk28);
        checks++; if (c_wr_addr.size() != C_BYTES) begin errors++; $display("FAIL fast_write_count: got %0d want %0d", c_wr_addr.size(), C_BYTES); end
        checks++; if (c_seq_bad() != 0) begin errors++; $display("FAIL fast_write_sequence: %0d bad records, want 0", c_seq_bad()); end
        checks++;
        if (c_wr_addr.size() == 0 || c_wr_addr[$] !== 17'(C_BYTES - 1)) begin
            errors++; $display("FAIL fast_last_addr: got %h want %h", (c_wr_addr.size() == 0) ? 17'h0 : c_wr_addr[$], 17'(C_BYTES - 1));
        end
        checks++; if (c_active !== 1'b0) begin errors++; $display("FAIL fast_active_after: got %b want 0", c_active); end
        checks++; if (c_cmd !== {8'h03, BASE}) begin errors++; $display("FAIL fast_cmd: got %h want %h", c_cmd, {8'h03, BASE}); end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_abort();
        test_extra_start();
        test_zero_len();
        test_fast();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
